// File: rtl/bp_dma_mem_responder.sv
// bp_dma_mem_responder: memory-side DMA responder for one L2 bank.
// Services block reads as fill beats and block writes as evict beats against
// a word-addressed storage array. Storage indices wrap modulo mem_els_p.
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   dma_pkt_i/_v_i/_ready_and_o      request {write_not_read, byte addr}
//   dma_data_o/_v_o/_ready_and_i     read fill beats out
//   dma_data_i/_v_i/_ready_and_o     write (evict) beats in
//   busy_o                           transaction in progress
//   err_o                            sticky out-of-range flag, present only
//                                    with BP_DMA_MEM_RESP_RANGE_CHECK_EN
module bp_dma_mem_responder #(
   parameter int daddr_width_p         = 28,
   parameter int fill_width_p          = 64,
   parameter int block_size_in_words_p = 8,
   parameter int word_width_p          = 64,
   parameter int mem_els_p             = 4096,
   localparam int pkt_width_lp         = 1 + daddr_width_p
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [pkt_width_lp-1:0]  dma_pkt_i,
   input  logic                     dma_pkt_v_i,
   output logic                     dma_pkt_ready_and_o,
   output logic [fill_width_p-1:0]  dma_data_o,
   output logic                     dma_data_v_o,
   input  logic                     dma_data_ready_and_i,
   input  logic [fill_width_p-1:0]  dma_data_i,
   input  logic                     dma_data_v_i,
   output logic                     dma_data_ready_and_o,
   output logic                     busy_o
`ifdef BP_DMA_MEM_RESP_RANGE_CHECK_EN
  ,output logic                     err_o
`endif
);

   localparam int fill_bytes_lp  = fill_width_p / 8;
   localparam int block_bytes_lp = block_size_in_words_p * word_width_p / 8;
   localparam int beats_lp       = block_size_in_words_p * word_width_p / fill_width_p;
   localparam int cnt_width_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam int idx_width_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
   localparam logic [daddr_width_p-1:0] blk_mask_lp = daddr_width_p'(block_bytes_lp - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_PREP,
      READ,
      WRITE
   } state_e;

   state_e                    state_q;
   logic [cnt_width_lp-1:0]   cnt_q;
   logic [daddr_width_p-1:0]  base_q;
   logic [fill_width_p-1:0]   data_q;
   logic                      pkt_ready_q;
   logic                      data_v_q;
   logic                      data_ready_q;
   logic                      busy_q;
   logic [fill_width_p-1:0]   mem_q [mem_els_p];

   logic                      pkt_wnr;
   logic [daddr_width_p-1:0]  pkt_base;
   logic [daddr_width_p-1:0]  beat_addr;
   logic [idx_width_lp-1:0]   base_idx;
   logic [cnt_width_lp-1:0]   rd_cnt;
   logic [idx_width_lp-1:0]   rd_idx;
   logic [idx_width_lp-1:0]   wr_idx;
   logic [fill_width_p-1:0]   rd_word;
   logic                      last_beat;
   logic                      pkt_hs;
   logic                      wr_en;
   logic                      unused_addr;

   assign pkt_wnr   = dma_pkt_i[pkt_width_lp-1];
   assign pkt_base  = dma_pkt_i[daddr_width_p-1:0] & ~blk_mask_lp;
   assign pkt_hs    = dma_pkt_v_i & pkt_ready_q;
   assign beat_addr = base_q / daddr_width_p'(fill_bytes_lp);
   assign base_idx  = beat_addr[idx_width_lp-1:0];
   assign last_beat = (cnt_q == cnt_width_lp'(beats_lp - 1));

   // upper address bits fall away in the modulo-storage wrap
   assign unused_addr = ^beat_addr[daddr_width_p-1:idx_width_lp];

   // in READ the register is refilled with the beat after the one leaving
   assign rd_cnt = (state_q == READ) ? cnt_q + 1'b1 : cnt_q;
   assign rd_idx = base_idx + idx_width_lp'(rd_cnt);
   assign wr_idx = base_idx + idx_width_lp'(cnt_q);

`ifdef BP_DMA_MEM_RESP_RANGE_CHECK_EN
   localparam logic [63:0] mem_bytes_lp = 64'(mem_els_p) * 64'(fill_bytes_lp);

   logic oor_q;
   logic err_q;
   logic pkt_oor;

   assign pkt_oor = (64'(pkt_base) >= mem_bytes_lp);
   assign rd_word = oor_q ? '0 : mem_q[rd_idx];
   assign wr_en   = (state_q == WRITE) & dma_data_v_i & data_ready_q & ~oor_q;
   assign err_o   = err_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         oor_q <= 1'b0;
         err_q <= 1'b0;
      end else if (state_q == IDLE && pkt_hs) begin
         oor_q <= pkt_oor;
         err_q <= err_q | pkt_oor;
      end
   end
`else
   assign rd_word = mem_q[rd_idx];
   assign wr_en   = (state_q == WRITE) & dma_data_v_i & data_ready_q;
`endif

   // storage is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_idx] <= dma_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         base_q       <= '0;
         data_q       <= '0;
         pkt_ready_q  <= 1'b0;
         data_v_q     <= 1'b0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               pkt_ready_q <= 1'b1;
               if (pkt_hs) begin
                  base_q      <= pkt_base;
                  cnt_q       <= '0;
                  pkt_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (pkt_wnr) begin
                     state_q      <= WRITE;
                     data_ready_q <= 1'b1;
                  end else begin
                     state_q <= READ_PREP;
                  end
               end
            end
            READ_PREP: begin
               state_q  <= READ;
               data_v_q <= 1'b1;
               data_q   <= rd_word;
            end
            READ: begin
               if (dma_data_ready_and_i) begin
                  if (last_beat) begin
                     state_q     <= IDLE;
                     data_v_q    <= 1'b0;
                     busy_q      <= 1'b0;
                     pkt_ready_q <= 1'b1;
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     data_q <= rd_word;
                  end
               end
            end
            WRITE: begin
               if (dma_data_v_i) begin
                  if (last_beat) begin
                     state_q      <= IDLE;
                     data_ready_q <= 1'b0;
                     busy_q       <= 1'b0;
                     pkt_ready_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dma_pkt_ready_and_o  = pkt_ready_q;
   assign dma_data_o           = data_q;
   assign dma_data_v_o         = data_v_q;
   assign dma_data_ready_and_o = data_ready_q;
   assign busy_o               = busy_q;

endmodule

// File: doc/bp_dma_mem_responder.md
Name: bp_dma_mem_responder

Overview:
- Memory-side responder for the per-bank L2 cache DMA interface that the unicore toplevel exposes.
- Accepts DMA packets and services them against an internal word-addressed storage array:
  - reads return one block as fill beats;
  - writes consume eviction beats into storage.
- One instance per L2 bank. Used as the DRAM stand-in for block-level testbenches and FPGA bring-up.

Parameters:
- daddr_width_p, 28, DMA byte address width.
- fill_width_p, 64, data beat width in bits; multiple of 8.
- block_size_in_words_p, 8, cache block size in words.
- word_width_p, 64, cache word width in bits.
- mem_els_p, 4096, storage depth in fill_width_p entries; power of 2.
- Derived: beats_lp = block_size_in_words_p*word_width_p/fill_width_p (integer ≥1); pkt_width_lp = 1+daddr_width_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- dma_pkt_i  in  pkt_width_lp  DMA request; MSB = write_not_read, low daddr_width_p bits = byte address.
- dma_pkt_v_i  in  1  request valid.
- dma_pkt_ready_and_o  out  1  request accepted when high with valid.
- dma_data_o  out  fill_width_p  read fill beat.
- dma_data_v_o  out  1  fill beat valid.
- dma_data_ready_and_i  in  1  fill beat consumed when high with valid.
- dma_data_i  in  fill_width_p  write (evict) beat.
- dma_data_v_i  in  1  evict beat valid.
- dma_data_ready_and_o  out  1  evict beat accepted when high with valid.
- busy_o  out  1  a transaction is in progress.

Behaviour:
- Reset, asserted asynchronously:
  - FSM goes to IDLE; beat counter 0.
  - dma_pkt_ready_and_o=0, dma_data_v_o=0, dma_data_ready_and_o=0, busy_o=0, dma_data_o=0.
  - Storage contents are not reset.
  - Reset mid-transaction abandons it silently; partial write beats already stored remain.
- Address mapping:
  - Block base = addr with its low log2(block bytes) bits forced to 0.
  - Entry index for beat k = ((base / (fill_width_p/8)) + k) mod mem_els_p, so indices wrap at the top of storage.
- States:
  - IDLE:
    - dma_pkt_ready_and_o=1.
    - On pkt handshake: latch base, clear counter.
    - write_not_read=1 → WRITE; else → READ_PREP.
  - READ_PREP:
    - One cycle; performs the synchronous read of beat 0 into the output register.
    - → READ.
  - READ:
    - dma_data_v_o=1, dma_data_o = registered beat.
    - On handshake: if counter==beats_lp-1 → IDLE, with dma_data_v_o dropping the next cycle; else counter++ and the output register loads the next beat in the same cycle, so beats are back-to-back with no bubble.
    - Data and valid hold stable while ready is low.
  - WRITE:
    - dma_data_ready_and_o=1.
    - Each handshake writes dma_data_i to the entry for the current counter value, then counter++.
    - Handshake at counter==beats_lp-1 → IDLE.
- Latency: pkt handshake cycle N → first read beat valid at cycle N+2.
- Write data is written the cycle it is accepted; a read packet accepted the next cycle returns the new data.
- No overlap:
  - dma_pkt_ready_and_o=0 in all non-IDLE states.
  - dma_data_ready_and_o is 1 only in WRITE.
  - dma_data_v_o is 1 only in READ.
- busy_o = (state != IDLE).
- Counter width is clog2(beats_lp), minimum 1 bit. When beats_lp=1, every transaction is a single beat.

Optional Feature:
- Macro BP_DMA_MEM_RESP_RANGE_CHECK_EN.
- When defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o is set sticky when an accepted packet's block base is ≥ mem_els_p*(fill_width_p/8); it clears only on reset.
  - Out-of-range reads return all-zero beats.
  - Out-of-range writes are accepted and their beats discarded.
  - Handshake timing is unchanged.
- When undefined: no err_o port, and all addresses wrap modulo the storage size as described.

Test Plan:
- Write then read: write pkt addr 0x40 with beats 0x1..0x8, then read pkt 0x40 → 8 beats 0x1..0x8 in order; first dma_data_v_o exactly 2 cycles after the read pkt handshake.
- Unaligned address: read pkt 0x47 after the above → identical 8 beats; low address bits ignored.
- Backpressure: hold dma_data_ready_and_i low for 5 cycles during beat 3 → beat 3 value and valid stay stable; no beat skipped or duplicated; 8 beats total.
- Write stalls: dma_data_v_i toggling every other cycle for a write to 0x80 → exactly 8 beats stored; dma_pkt_ready_and_o stays 0 until the 8th beat is accepted.
- Reset mid-read after 3 beats → all outputs 0 in the same cycle; after release a new read of 0x40 returns the full 8-beat block.
- Wrap / range check: with mem_els_p=64, write to address 64*8 (0x200):
  - Without the macro, a read of 0x0 returns that data.
  - With the macro, err_o goes 1 and a read of 0x200 returns zeros.
